regfile_wr_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources: A (ALU) and B (load unit).

---
 rtl/regfile_wr_arbiter_pkg.sv | 19 +
 rtl/regfile_wr_arbiter_wr_fifo.sv | 62 ++++++
 rtl/regfile_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: source encoding and default widths.
// Imported by regfile_wr_arbiter and its per-source queue.
package regfile_wr_arbiter_pkg;

    localparam int unsigned WORD_SIZE_DEF   = 32;
    localparam int unsigned INDEX_WIDTH_DEF = 4;
    localparam int unsigned FIFO_DEPTH_DEF  = 2;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // Round-robin handoff: after a grant the pointer names the source that lost.
    function automatic src_e other_src(input src_e s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_wr_fifo.sv
// wr_fifo: small synchronous FIFO holding {regno,data} writes for one writeback source.
// full/empty decode only from the registered count, so ready never depends on this cycle's push or pop.
module wr_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == CNT_W'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin sharing of the register file write port between ALU (A) and load unit (B).
// Optional feature macro WR_BYPASS_EN adds forwarding of the in-flight write to two read ports.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [INDEX_WIDTH-1:0] a_regno,
    input  logic [WORD_SIZE-1:0]   a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [INDEX_WIDTH-1:0] b_regno,
    input  logic [WORD_SIZE-1:0]   b_data,
    output logic                   rf_wrtEn,
    output logic [INDEX_WIDTH-1:0] rf_wrtRegno,
    output logic [WORD_SIZE-1:0]   rf_dataIn,
    output logic                   idle
`ifdef WR_BYPASS_EN
    ,
    input  logic [INDEX_WIDTH-1:0] rd_regno1,
    input  logic [INDEX_WIDTH-1:0] rd_regno2,
    output logic                   fwd_hit1,
    output logic                   fwd_hit2,
    output logic [WORD_SIZE-1:0]   fwd_data1,
    output logic [WORD_SIZE-1:0]   fwd_data2
`endif
);

    localparam int unsigned ENTRY_W = INDEX_WIDTH + WORD_SIZE;

    logic [ENTRY_W-1:0] a_head;
    logic [ENTRY_W-1:0] b_head;
    logic [ENTRY_W-1:0] head_c;
    logic               a_full;
    logic               b_full;
    logic               a_empty;
    logic               b_empty;
    logic               a_push;
    logic               b_push;
    logic               a_pop_c;
    logic               b_pop_c;
    logic               grant_c;
    src_e               grant_src_c;
    src_e               rr_ptr;

    assign a_ready = !a_full;
    assign b_ready = !b_full;
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;

    wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (a_push),
        .push_data ({a_regno, a_data}),
        .pop       (a_pop_c),
        .pop_data  (a_head),
        .full      (a_full),
        .empty     (a_empty)
    );

    wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (b_push),
        .push_data ({b_regno, b_data}),
        .pop       (b_pop_c),
        .pop_data  (b_head),
        .full      (b_full),
        .empty     (b_empty)
    );

    // Grant: a lone non-empty queue wins outright; contention is settled by rr_ptr.
    always_comb begin
        grant_c     = 1'b0;
        grant_src_c = SRC_A;
        if (!a_empty && !b_empty) begin
            grant_c     = 1'b1;
            grant_src_c = rr_ptr;
        end else if (!a_empty) begin
            grant_c     = 1'b1;
            grant_src_c = SRC_A;
        end else if (!b_empty) begin
            grant_c     = 1'b1;
            grant_src_c = SRC_B;
        end
    end

    assign a_pop_c = grant_c && (grant_src_c == SRC_A);
    assign b_pop_c = grant_c && (grant_src_c == SRC_B);
    assign head_c  = (grant_src_c == SRC_A) ? a_head : b_head;

    // Write stage: the popped head drives the register file for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= SRC_A;
            rf_wrtEn    <= 1'b0;
            rf_wrtRegno <= '0;
            rf_dataIn   <= '0;
        end else begin
            rf_wrtEn <= grant_c;
            if (grant_c) begin
                rr_ptr      <= other_src(grant_src_c);
                rf_wrtRegno <= head_c[ENTRY_W-1 -: INDEX_WIDTH];
                rf_dataIn   <= head_c[WORD_SIZE-1:0];
            end
        end
    end

    assign idle = a_empty && b_empty && !rf_wrtEn;

`ifdef WR_BYPASS_EN
    // The staged write lands at the next edge; expose it to same-cycle readers.
    assign fwd_hit1  = rf_wrtEn && (rd_regno1 == rf_wrtRegno);
    assign fwd_hit2  = rf_wrtEn && (rd_regno2 == rf_wrtRegno);
    assign fwd_data1 = rf_dataIn;
    assign fwd_data2 = rf_dataIn;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed pushes, expected writes queued in order, monitor compares rf_* writes.
// Forwarding checks are compiled in when WR_BYPASS_EN is defined.
module tb_regfile_wr_arbiter;

    typedef struct packed {
        logic [3:0]  regno;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [3:0]  a_regno = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [3:0]  b_regno = '0;
    logic [31:0] b_data = '0;
    logic        rf_wrtEn;
    logic [3:0]  rf_wrtRegno;
    logic [31:0] rf_dataIn;
    logic        idle;
`ifdef WR_BYPASS_EN
    logic [3:0]  rd_regno1 = '0;
    logic [3:0]  rd_regno2 = '0;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  n_wr  = 0;

    regfile_wr_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_regno     (a_regno),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_regno     (b_regno),
        .b_data      (b_data),
        .rf_wrtEn    (rf_wrtEn),
        .rf_wrtRegno (rf_wrtRegno),
        .rf_dataIn   (rf_dataIn),
        .idle        (idle)
`ifdef WR_BYPASS_EN
        ,
        .rd_regno1   (rd_regno1),
        .rd_regno2   (rd_regno2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must be the next expected entry.
    always @(negedge clk) begin
        if (!reset && rf_wrtEn) begin
            n_wr++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got r%0d/0x%08h, want no write", rf_wrtRegno, rf_dataIn);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_wrtRegno !== e.regno || rf_dataIn !== e.data) begin
                    n_err++;
                    $display("FAIL write_order: got r%0d/0x%08h, want r%0d/0x%08h",
                             rf_wrtRegno, rf_dataIn, e.regno, e.data);
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check({name, "_idle"}, 32'(idle), 32'd1);
    endtask

    // Both sources push n entries as fast as ready allows; expected drain is strictly A,B,A,B,...
    task automatic run_dual(input int n, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [31:0] base_a, input logic [31:0] base_b,
                            output bit saw_a_full, output bit saw_b_full);
        int ia;
        int ib;
        int guard;
        bit acc_a;
        bit acc_b;
        ia = 0;
        ib = 0;
        guard = 0;
        saw_a_full = 1'b0;
        saw_b_full = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(wr_t'{regno: ra, data: base_a + 32'(i)});
            exp_q.push_back(wr_t'{regno: rb, data: base_b + 32'(i)});
        end
        while ((ia < n || ib < n) && guard < 200) begin
            @(negedge clk);
            a_valid = (ia < n);
            a_regno = ra;
            a_data  = base_a + 32'(ia);
            b_valid = (ib < n);
            b_regno = rb;
            b_data  = base_b + 32'(ib);
            if (a_valid && !a_ready) saw_a_full = 1'b1;
            if (b_valid && !b_ready) saw_b_full = 1'b1;
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (acc_a) ia++;
            if (acc_b) ib++;
            a_valid = 1'b0;
            b_valid = 1'b0;
            guard++;
        end
        check("dual_push_done", 32'((ia == n) && (ib == n)), 32'd1);
    endtask

    initial begin
        bit sa;
        bit sb;
        int wr_before;

        // 1: reset held two cycles
        do_reset(2);
        check("rst_wrtEn", 32'(rf_wrtEn), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_wrtRegno", 32'(rf_wrtRegno), 32'd0);
        check("rst_dataIn", rf_dataIn, 32'd0);

        // 2: single A write, pop at t+1, regfile write at t+2
        @(negedge clk);
        a_valid = 1'b1;
        a_regno = 4'd3;
        a_data  = 32'hDEADBEEF;
        exp_q.push_back(wr_t'{regno: 4'd3, data: 32'hDEADBEEF});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        check("single_wrtEn_t", 32'(rf_wrtEn), 32'd0);
        check("single_busy_t", 32'(idle), 32'd0);
        @(negedge clk);
        check("single_wrtEn_t1", 32'(rf_wrtEn), 32'd1);
        check("single_regno_t1", 32'(rf_wrtRegno), 32'd3);
        check("single_data_t1", rf_dataIn, 32'hDEADBEEF);
        @(negedge clk);
        check("single_wrtEn_t2", 32'(rf_wrtEn), 32'd0);
        check("single_idle_after", 32'(idle), 32'd1);
        check("single_regno_hold", 32'(rf_wrtRegno), 32'd3);

        // 3: alternating grants from reset, starting with A
        do_reset(1);
        run_dual(4, 4'd1, 4'd2, 32'h10, 32'h20, sa, sb);
        wait_drain("alternate");

        // 4: sustained pressure fills the 2-deep queues
        do_reset(1);
        wr_before = n_wr;
        run_dual(8, 4'd4, 4'd9, 32'h100, 32'h900, sa, sb);
        wait_drain("sustained");
        check("sustained_a_backpressure", 32'(sa), 32'd1);
        check("sustained_b_backpressure", 32'(sb), 32'd1);
        check("sustained_write_count", 32'(n_wr - wr_before), 32'd16);

        // 5: reset with entries queued and staged discards them all
        do_reset(1);
        run_dual(2, 4'd7, 4'd8, 32'h700, 32'h800, sa, sb);
        check("flush_pre_busy", 32'(idle), 32'd0);
        do_reset(1);
        check("flush_wrtEn", 32'(rf_wrtEn), 32'd0);
        check("flush_idle", 32'(idle), 32'd1);
        check("flush_a_ready", 32'(a_ready), 32'd1);
        wr_before = n_wr;
        repeat (6) @(negedge clk);
        check("flush_no_writes", 32'(n_wr - wr_before), 32'd0);

`ifdef WR_BYPASS_EN
        // 6: forwarding of the in-flight write
        do_reset(1);
        rd_regno1 = 4'd5;
        rd_regno2 = 4'd6;
        @(negedge clk);
        a_valid = 1'b1;
        a_regno = 4'd5;
        a_data  = 32'h55;
        exp_q.push_back(wr_t'{regno: 4'd5, data: 32'h55});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        check("fwd_hit1_early", 32'(fwd_hit1), 32'd0);
        @(negedge clk);
        check("fwd_hit1", 32'(fwd_hit1), 32'd1);
        check("fwd_data1", fwd_data1, 32'h55);
        check("fwd_hit2", 32'(fwd_hit2), 32'd0);
        check("fwd_data2", fwd_data2, 32'h55);
        @(negedge clk);
        check("fwd_hit1_after", 32'(fwd_hit1), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
